// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int unsigned MAX_WAIT_DEF = 4;

  // Bit positions of the requesters in the request/grant vectors.
  localparam int unsigned SEL_IF = 0;
  localparam int unsigned SEL_D  = 1;

endpackage

// File: rtl/m_mem_arb_if.sv
// Requester and memory-side bus of the unified memory arbiter.
interface m_mem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          w_if_req;
  logic [AW-1:0] w_if_addr;
  logic          w_if_gnt;
  logic          w_if_rvalid;
  logic [DW-1:0] w_if_rdata;

  logic          w_d_req;
  logic          w_d_we;
  logic [AW-1:0] w_d_addr;
  logic [DW-1:0] w_d_wdata;
  logic          w_d_gnt;
  logic          w_d_rvalid;
  logic [DW-1:0] w_d_rdata;

  logic          w_m_req;
  logic          w_m_we;
  logic [AW-1:0] w_m_addr;
  logic [DW-1:0] w_m_wdata;
  logic          w_m_ready;
  logic [DW-1:0] w_m_rdata;

  // Arbiter side.
  modport slave (
    input  w_if_req, w_if_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_ready, w_m_rdata,
    output w_if_gnt, w_if_rvalid, w_if_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
    output w_m_req, w_m_we, w_m_addr, w_m_wdata
  );

  // Requesters plus memory, as seen from the environment.
  modport master (
    output w_if_req, w_if_addr, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_ready, w_m_rdata,
    input  w_if_gnt, w_if_rvalid, w_if_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
    input  w_m_req, w_m_we, w_m_addr, w_m_wdata
  );
endinterface

// File: rtl/m_arb_sel.sv
// Combinational priority select: data over fetch unless fetch has starved.
module m_arb_sel
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       prio_if,
  input  logic       ready,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (ready) begin
      if (prio_if && reqs[SEL_IF]) begin
        gnt[SEL_IF] = 1'b1;
      end else if (reqs[SEL_D]) begin
        gnt[SEL_D] = 1'b1;
      end else if (reqs[SEL_IF]) begin
        gnt[SEL_IF] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_mem_arb.sv
// Shares one synchronous-read memory between fetch and load/store, with a
// starvation counter bounding how long fetch can lose to data accesses.
module m_mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input logic        w_clk,
  input logic        w_rst_n,
  m_mem_arb_if.slave bus
);

  localparam int unsigned   SW      = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MaxWait = SW'(MAX_WAIT);

  logic [1:0]    owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    gnt;
  logic          prio_if;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  assign prio_if = (starve_q == MaxWait);

  // Gating ready with reset keeps every grant low while in reset.
  m_arb_sel u_sel (
    .reqs    ({bus.w_d_req, bus.w_if_req}),
    .prio_if (prio_if),
    .ready   (bus.w_m_ready & w_rst_n),
    .gnt     (gnt)
  );

  always_comb begin
    m_req   = |gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt[SEL_D]) begin
      m_we    = bus.w_d_we;
      m_addr  = bus.w_d_addr;
      m_wdata = bus.w_d_wdata;
    end else if (gnt[SEL_IF]) begin
      m_addr = bus.w_if_addr;
    end
  end

  // A grant implies ready, so every granted read returns data next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (m_req && !m_we) begin
      owner_d = gnt[SEL_D] ? OWN_D : OWN_IF;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt[SEL_IF] || !bus.w_if_req) begin
      starve_d = '0;
    end else if (bus.w_m_ready && (starve_q != MaxWait)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign bus.w_if_gnt    = gnt[SEL_IF];
  assign bus.w_d_gnt     = gnt[SEL_D];
  assign bus.w_m_req     = m_req;
  assign bus.w_m_we      = m_we;
  assign bus.w_m_addr    = m_addr;
  assign bus.w_m_wdata   = m_wdata;
  assign bus.w_if_rvalid = (owner_q == OWN_IF);
  assign bus.w_d_rvalid  = (owner_q == OWN_D);
  assign bus.w_if_rdata  = bus.w_m_rdata;
  assign bus.w_d_rdata   = bus.w_m_rdata;

endmodule

// File: tb/tb_m_mem_arb.sv
// Bench for m_mem_arb: directed scenarios plus random traffic against a
// memory-level reference model that tracks contents and the returned data.
module tb_m_mem_arb;

  localparam int unsigned MW = 4;

  logic w_clk = 1'b0;
  logic w_rst_n;
  always #5 w_clk = ~w_clk;

  m_mem_arb_if #(.AW(32), .DW(32)) bus ();

  m_mem_arb #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] mdl_mem [256];
  int          mdl_own    = 0;
  int          mdl_starve = 0;
  logic [31:0] mdl_pend   = '0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i) * 32'd7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers accepted reads one cycle later, junk otherwise.
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge w_clk);
      if (bus.w_m_req && bus.w_m_ready) begin
        if (bus.w_m_we) begin
          mem_arr[bus.w_m_addr[9:2]] = bus.w_m_wdata;
          bus.w_m_rdata <= $urandom;
        end else begin
          bus.w_m_rdata <= mem_arr[bus.w_m_addr[9:2]];
        end
      end else begin
        bus.w_m_rdata <= $urandom;
      end
    end
  end

  // Reference model and per-cycle compare, sampled mid-low-phase.
  initial begin
    int sel;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
    forever begin
      @(negedge w_clk);
      #1;
      sel = 0;
      if (w_rst_n && bus.w_m_ready) begin
        if (mdl_starve == MW && bus.w_if_req) sel = 1;
        else if (bus.w_d_req)                 sel = 2;
        else if (bus.w_if_req)                sel = 1;
      end
      chk("if_gnt", 32'(bus.w_if_gnt), 32'(sel == 1));
      chk("d_gnt", 32'(bus.w_d_gnt), 32'(sel == 2));
      chk("m_req", 32'(bus.w_m_req), 32'(sel != 0));
      chk("m_we", 32'(bus.w_m_we), 32'(sel == 2 && bus.w_d_we));
      chk("m_addr", bus.w_m_addr,
          (sel == 1) ? bus.w_if_addr : (sel == 2) ? bus.w_d_addr : 32'h0);
      if (sel != 1) chk("m_wdata", bus.w_m_wdata, (sel == 2) ? bus.w_d_wdata : 32'h0);
      chk("if_rvalid", 32'(bus.w_if_rvalid), 32'(mdl_own == 1));
      chk("d_rvalid", 32'(bus.w_d_rvalid), 32'(mdl_own == 2));
      chk("if_rdata_pass", bus.w_if_rdata, bus.w_m_rdata);
      chk("d_rdata_pass", bus.w_d_rdata, bus.w_m_rdata);
      if (mdl_own == 1) chk("if_rdata_model", bus.w_if_rdata, mdl_pend);
      if (mdl_own == 2) chk("d_rdata_model", bus.w_d_rdata, mdl_pend);

      if (!w_rst_n) begin
        mdl_own    = 0;
        mdl_starve = 0;
      end else begin
        if (sel == 2 && bus.w_d_we) begin
          mdl_mem[bus.w_d_addr[9:2]] = bus.w_d_wdata;
          mdl_own = 0;
        end else if (sel != 0) begin
          a        = (sel == 1) ? bus.w_if_addr : bus.w_d_addr;
          mdl_pend = mdl_mem[a[9:2]];
          mdl_own  = sel;
        end else begin
          mdl_own = 0;
        end
        if (sel == 1 || !bus.w_if_req) mdl_starve = 0;
        else if (bus.w_m_ready && mdl_starve < MW) mdl_starve++;
      end
    end
  end

  task automatic apply(input logic rst, input logic rdy, input logic ireq,
                       input logic [31:0] iaddr, input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    @(posedge w_clk);
    #1;
    w_rst_n       = rst;
    bus.w_m_ready = rdy;
    bus.w_if_req  = ireq;
    bus.w_if_addr = iaddr;
    bus.w_d_req   = dreq;
    bus.w_d_we    = dwe;
    bus.w_d_addr  = daddr;
    bus.w_d_wdata = dwd;
    #6;
  endtask

  initial begin
    logic        ip, dp, dwe, rst, rdy;
    logic [31:0] ia, da, dwd;
    w_rst_n       = 1'b0;
    bus.w_m_ready = 1'b1;
    bus.w_if_req  = 1'b0;
    bus.w_if_addr = '0;
    bus.w_d_req   = 1'b0;
    bus.w_d_we    = 1'b0;
    bus.w_d_addr  = '0;
    bus.w_d_wdata = '0;

    // Reset with both requesting.
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 32'h0);
      chk("rst_gnt", 32'({bus.w_if_gnt, bus.w_d_gnt}), 32'd0);
      chk("rst_mreq", 32'(bus.w_m_req), 32'd0);
    end
    chk("rst_rvalid", 32'({bus.w_if_rvalid, bus.w_d_rvalid}), 32'd0);
    apply(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 32'h0);
    chk("post_rst_dgnt", 32'(bus.w_d_gnt), 32'd1);
    chk("post_rst_ifgnt", 32'(bus.w_if_gnt), 32'd0);
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("first_load_rvalid", 32'(bus.w_d_rvalid), 32'd1);
    chk("first_load_data", bus.w_d_rdata, 32'h1000_01C7);

    // Single fetch.
    apply(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fetch_gnt", 32'(bus.w_if_gnt), 32'd1);
    chk("fetch_addr", bus.w_m_addr, 32'h100);
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fetch_rvalid", 32'(bus.w_if_rvalid), 32'd1);
    chk("fetch_data", bus.w_if_rdata, 32'h0000_0013);
    chk("fetch_no_drvalid", 32'(bus.w_d_rvalid), 32'd0);

    // Contention: fetch wins every fifth ready cycle.
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 32'h10c, 32'h0);
      chk("cont_if", 32'(bus.w_if_gnt), 32'(i == 4 || i == 9));
      chk("cont_d", 32'(bus.w_d_gnt), 32'(!(i == 4 || i == 9)));
    end

    // Store then load.
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    chk("store_we", 32'(bus.w_m_we), 32'd1);
    chk("store_wdata", bus.w_m_wdata, 32'hDEAD_BEEF);
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("store_no_rvalid", 32'(bus.w_d_rvalid), 32'd0);
    chk("load_gnt", 32'(bus.w_d_gnt), 32'd1);
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("load_rvalid", 32'(bus.w_d_rvalid), 32'd1);
    chk("load_data", bus.w_d_rdata, 32'hDEAD_BEEF);

    // Ready low: stall holds the starvation count, owed response still arrives.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 1'b0, 32'h114, 32'h0);
      chk("pre_stall_d", 32'(bus.w_d_gnt), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 1'b0, 32'h114, 32'h0);
      chk("stall_gnt", 32'({bus.w_if_gnt, bus.w_d_gnt, bus.w_m_req}), 32'd0);
      chk("stall_rvalid", 32'(bus.w_d_rvalid), 32'(i == 0));
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 1'b0, 32'h114, 32'h0);
      chk("post_stall_if", 32'(bus.w_if_gnt), 32'(i == 2));
    end

    // Reset drops an outstanding fetch read.
    apply(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mid_fetch_gnt", 32'(bus.w_if_gnt), 32'd1);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mid_rst_rvalid", 32'(bus.w_if_rvalid), 32'd1);
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("after_rst_rvalid", 32'({bus.w_if_rvalid, bus.w_d_rvalid}), 32'd0);

    // Random traffic; requesters hold their request until granted.
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(0, 9) < 6) begin
        ip = 1'b1;
        ia = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp  = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        da  = 32'h100 + (32'($urandom_range(0, 15)) << 2);
        dwd = $urandom;
      end
      rdy = ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 99) != 0);
      apply(rst, rdy, ip, ia, dp, dwe, da, dwd);
      if (bus.w_if_gnt) ip = 1'b0;
      if (bus.w_d_gnt)  dp = 1'b0;
    end

    apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_mem_arb.md
# m_mem_arb

Two-requester arbiter sharing one single-ported, synchronous-read memory between the instruction-fetch stage and the load/store unit of the 2-stage RV32I pipeline. It replaces the separate instruction and data memories with one unified memory. Data accesses have fixed priority over fetch, and a starvation counter bounds fetch wait. The block grants each cycle, muxes address, write-enable and write data, and steers the 1-cycle-latency read data back to the owning requester.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive ready-cycles fetch may lose before it is forced ahead of data (≥1)
- w_clk  in  1  clock, all state on posedge
- w_rst_n  in  1  reset, synchronous, active-low
- w_if_req  in  1  fetch request; w_if_addr held stable until granted
- w_if_addr  in  AW  fetch address
- w_if_gnt  out  1  fetch accepted this cycle
- w_if_rvalid  out  1  w_if_rdata valid this cycle
- w_if_rdata  out  DW  fetch read data
- w_d_req  in  1  data request; addr/we/wdata held until granted
- w_d_we  in  1  1 = store, 0 = load
- w_d_addr  in  AW  data address
- w_d_wdata  in  DW  store data
- w_d_gnt  out  1  data accepted this cycle
- w_d_rvalid  out  1  w_d_rdata valid (loads only)
- w_d_rdata  out  DW  load data
- w_m_req  out  1  memory access this cycle
- w_m_we  out  1  memory write enable
- w_m_addr  out  AW  memory address
- w_m_wdata  out  DW  memory write data
- w_m_ready  in  1  memory can accept this cycle
- w_m_rdata  in  DW  read data, valid the cycle after an accepted read

## Operation
- State: owner_q ∈ {NONE, IF, D}, owner of the read issued last cycle; starve_q, counter 0..MAX_WAIT, saturating.
- prio_if = (starve_q == MAX_WAIT).
- Selection is combinational and evaluated only when w_m_ready=1 and w_rst_n=1:
  - If prio_if and w_if_req: select IF.
  - Else if w_d_req: select D.
  - Else if w_if_req: select IF.
  - Else: no selection.
- w_m_req = 1 iff a requester is selected. w_X_gnt = 1 for the selected requester only. w_m_addr/we/wdata come from the selected requester. IF forces w_m_we=0. With no selection, all memory outputs are 0.
- Access = w_m_req & w_m_ready.
- owner_q next value: IF or D if the access is a read, else NONE. Stores produce no response.
- w_if_rvalid = (owner_q==IF) and w_d_rvalid = (owner_q==D). Both rdata outputs carry w_m_rdata unconditionally, and consumers qualify them by rvalid.
- starve_q next value:
  - 0 if w_if_gnt or !w_if_req.
  - +1 (saturating) if w_if_req & !w_if_gnt & w_m_ready.
  - Unchanged if w_m_ready=0.
- Reset (w_rst_n=0 on an edge): owner_q←NONE, starve_q←0. While w_rst_n=0, all gnt, w_m_req and w_m_we are forced 0. Reset mid-operation drops the outstanding read, and both rvalid are 0 the cycle after reset.
- Reset values: all outputs 0, except the rdata outputs, which follow w_m_rdata.

## Timing
- Grant is combinational: a request is granted in the same cycle it is presented, if selected.
- Read latency is exactly 1 cycle: gnt at cycle t gives rvalid at t+1.
- Throughput is one access per cycle. Back-to-back reads from alternating owners are legal: the response at t+1 coexists with the grant at t+1.
- w_m_ready=0 stalls all grants. The response owed from the previous cycle is still delivered.
- Bound on fetch wait: with w_d_req held high, fetch is granted within MAX_WAIT+1 ready cycles.
- Simultaneous requests with prio_if=0: D wins and starve_q increments.
- Both requesters are single-outstanding by protocol (hold until gnt). The arbiter does not check this.

## Structure
- Shared package mem_arb_pkg holds:
  - Owner encoding constants OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2.
  - Default MAX_WAIT.
- One natural sub-module: m_arb_sel, the combinational priority select (inputs: reqs, prio_if, ready; outputs: one-hot grant). The top level holds owner_q, starve_q and the muxes.

## Test plan
- **Reset:** w_rst_n=0 for 2 cycles with both reqs high → all gnt/w_m_req/rvalid 0. First cycle after release → w_d_gnt=1.
- **Single fetch:** addr 0x100, w_m_rdata=0x00000013 at t+1 → w_if_gnt at t, w_if_rvalid=1 at t+1 with w_if_rdata=0x13, w_d_rvalid=0.
- **Contention, MAX_WAIT=4:** both reqs held, w_m_ready=1 → grants D,D,D,D,IF,D,D,D,D,IF…; starve_q reads 0,1,2,3,4,0.
- **Store then load:**
  - Store 0xDEADBEEF to 0x200 → w_m_we=1 and no rvalid the next cycle.
  - Load 0x200 → w_d_rvalid=1 the next cycle.
- **Ready low:** w_m_ready=0 for 3 cycles with both reqs → no gnt and starve_q unchanged. A prior read's rvalid is still asserted in the first stalled cycle.
- **Reset mid-read:** IF read granted at t, w_rst_n=0 at t+1 edge → w_if_rvalid=0 at t+2 and owner_q=NONE.
